// File: rtl/iir_pkg.sv
// iir_pkg: shared types, coefficient map and saturation helper for the biquad
package iir_pkg;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;
  localparam int NUM_TAPS = 5;
  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/iir_mac_unit.sv
// iir_mac_unit: shared signed multiply-accumulate with shift-and-saturate output
module iir_mac_unit
  import iir_pkg::*;
#(
  parameter int C_W   = 8,
  parameter int OP_W  = 16,
  parameter int ACC_W = 27,
  parameter int Y_W   = 16,
  parameter int FRAC  = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    sub_i,
  input  logic signed [C_W-1:0]   coef_i,
  input  logic signed [OP_W-1:0]  opnd_i,
  output logic signed [Y_W-1:0]   y_o,
  output logic                    sat_o
);
  logic signed [C_W+OP_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_q, acc_d, sum;
  logic signed [63:0] shifted, clamped;
  // y_o reflects the sum including the current term, so the last step needs no extra cycle
  always_comb begin
    prod    = coef_i * opnd_i;
    sum     = sub_i ? acc_q - ACC_W'(prod) : acc_q + ACC_W'(prod);
    acc_d   = clr_i ? '0 : en_i ? sum : acc_q;
    shifted = 64'(sum >>> FRAC);
    clamped = sat_clamp(shifted, Y_W);
    y_o     = clamped[Y_W-1:0];
    sat_o   = clamped != shifted;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/iir_biquad_seq.sv
// iir_biquad_seq: Direct Form I biquad, one shared MAC over five cycles per sample,
// programmable coefficient bank and valid/ready stream ports
module iir_biquad_seq
  import iir_pkg::*;
#(
  parameter int X_W       = 8,
  parameter int C_W       = 8,
  parameter int COEF_FRAC = 6,
  parameter int Y_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sleep,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [X_W-1:0] x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [Y_W-1:0] y,
  output logic                  out_sat,
  input  logic                  coef_we,
  input  logic [2:0]            coef_addr,
  input  logic signed [C_W-1:0] coef_wdata,
  output logic                  busy
);
  localparam int ACC_W = C_W + Y_W + 3;
  state_e state_q, state_d;
  logic [2:0] step_q, step_d;
  logic signed [X_W-1:0] x_q, x_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [Y_W-1:0] y1_q, y1_d, y2_q, y2_d, y_q, y_d;
  logic sat_q, sat_d, ov_q, ov_d;
  logic signed [C_W-1:0] coef_q [NUM_TAPS];
  logic signed [C_W-1:0] coef_d [NUM_TAPS];
  logic accept, last, msub, msat;
  logic signed [C_W-1:0] mcoef;
  logic signed [Y_W-1:0] mop, my;
  assign in_ready  = state_q == IDLE && !sleep;
  assign accept    = in_valid && in_ready;
  assign last      = state_q == MAC && step_q == 3'(NUM_TAPS - 1);
  assign busy      = state_q != IDLE;
  assign out_valid = ov_q;
  assign y         = y_q;
  assign out_sat   = sat_q;
  // coefficient addresses follow tap order, so the step indexes the bank directly
  assign mcoef = coef_q[step_q];
  assign msub  = step_q >= COEF_A1;
  assign mop   = step_q == COEF_B0 ? Y_W'(x_q)  :
                 step_q == COEF_B1 ? Y_W'(x1_q) :
                 step_q == COEF_B2 ? Y_W'(x2_q) :
                 step_q == COEF_A1 ? y1_q : y2_q;
  iir_mac_unit #(
    .C_W  (C_W),
    .OP_W (Y_W),
    .ACC_W(ACC_W),
    .Y_W  (Y_W),
    .FRAC (COEF_FRAC)
  ) u_mac (
    .clk    (clk),
    .reset_n(reset_n),
    .clr_i  (accept),
    .en_i   (state_q == MAC),
    .sub_i  (msub),
    .coef_i (mcoef),
    .opnd_i (mop),
    .y_o    (my),
    .sat_o  (msat)
  );
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    x_d     = x_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y_d     = y_q;
    sat_d   = sat_q;
    ov_d    = ov_q;
    coef_d  = coef_q;
    if (state_q == IDLE && coef_we && coef_addr < 3'(NUM_TAPS)) coef_d[coef_addr] = coef_wdata;
    unique case (state_q)
      IDLE: if (accept) begin
        x_d     = x;
        step_d  = '0;
        state_d = MAC;
      end
      MAC: begin
        step_d = step_q + 3'd1;
        if (last) begin
          y_d     = my;
          sat_d   = msat;
          ov_d    = 1'b1;
          x2_d    = x1_q;
          x1_d    = x_q;
          y2_d    = y1_q;
          y1_d    = my;
          state_d = OUT;
        end
      end
      OUT: if (out_ready) begin
        ov_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      x_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      ov_q    <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) coef_q[i] <= i == int'(COEF_B0) ? C_W'(1 << COEF_FRAC) : '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      x_q     <= x_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
      ov_q    <= ov_d;
      coef_q  <= coef_d;
    end
endmodule

// File: tb/tb_iir_biquad_seq.sv
// tb_iir_biquad_seq: random and directed stimulus checked against a plain-arithmetic biquad model
module tb_iir_biquad_seq;
  logic clk = 1'b0;
  logic reset_n, sleep, in_valid, out_ready, coef_we;
  logic [2:0] coef_addr;
  logic signed [7:0] x, coef_wdata;
  logic in_ready, out_valid, out_sat, busy;
  logic signed [15:0] y;
  int total = 0, passed = 0;
  int mb [5];
  longint mx1, mx2, my1, my2;

  iir_biquad_seq dut (
    .clk(clk), .reset_n(reset_n), .sleep(sleep), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_sat(out_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    mb = '{64, 0, 0, 0, 0};
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endtask

  task automatic predict(input longint xv, output longint ye, output bit es);
    longint acc, sh;
    acc = mb[0] * xv + mb[1] * mx1 + mb[2] * mx2 - mb[3] * my1 - mb[4] * my2;
    sh  = acc >>> 6;
    ye  = sh > 32767 ? 32767 : sh < -32768 ? -32768 : sh;
    es  = ye != sh;
    mx2 = mx1; mx1 = xv; my2 = my1; my1 = ye;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic wr(input int addr, input int val);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'(addr); coef_wdata = 8'(val);
    @(negedge clk);
    coef_we = 1'b0;
    if (addr < 5) mb[addr] = val;
  endtask

  task automatic sample(input int xv, input int hold, input bit slp, input bit bw);
    int n;
    longint ye;
    bit es;
    @(negedge clk);
    x = 8'(xv); in_valid = 1'b1; out_ready = hold == 0;
    chk("in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; n = 0;
    if (slp) sleep = 1'b1;
    if (bw) begin coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 8'($urandom_range(255)); end
    while (!out_valid && n < 20) begin
      @(negedge clk);
      coef_we = 1'b0;
      n++;
    end
    coef_we = 1'b0;
    predict(xv, ye, es);
    chk("latency", n, 5);
    chk("y", y, ye);
    chk("out_sat", out_sat, es);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_y", y, ye);
      chk("hold_ov", out_valid, 1);
      chk("hold_rdy", in_ready, 0);
      chk("hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    if (slp) begin
      @(negedge clk);
      chk("slp_ov", out_valid, 0);
      chk("slp_rdy", in_ready, 0);
      repeat (3) @(negedge clk);
      chk("slp_rdy_hold", in_ready, 0);
      sleep = 1'b0;
      #1;
      chk("wake_rdy", in_ready, 1);
    end
  endtask

  initial begin
    reset_n = 1'b0; sleep = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; x = '0;
    model_reset();
    #12;
    chk("rst_y", y, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_rdy", in_ready, 1);
    reset_n = 1'b1;
    sample(5, 0, 0, 0);
    sample(-7, 0, 0, 0);
    do_reset();
    wr(1, 64);
    wr(6, 99);
    foreach (mb[i]) if (i == 0) sample(10, 0, 0, 0); else if (i == 1) sample(20, 0, 0, 0);
    sample(30, 0, 0, 0);
    chk("fir_sum", y, 50);
    do_reset();
    wr(3, -32);
    sample(64, 0, 0, 0);
    for (int i = 0; i < 3; i++) sample(0, 0, 0, 0);
    chk("impulse_tail", y, 8);
    do_reset();
    wr(0, 127); wr(3, -64);
    for (int i = 0; i < 135; i++) sample(127, 0, 0, 0);
    chk("clamp_hi", y, 32767);
    chk("clamp_hi_sat", out_sat, 1);
    do_reset();
    wr(0, 127); wr(3, -64);
    for (int i = 0; i < 135; i++) sample(-128, 0, 0, 0);
    chk("clamp_lo", y, -32768);
    do_reset();
    wr(0, 50); wr(2, 20); wr(4, 16);
    sample(40, 10, 0, 0);
    sample(-25, 0, 1, 0);
    sample(17, 0, 0, 0);
    sample(90, 0, 0, 1);
    sample(-60, 0, 0, 1);
    wr(1, 30);
    @(negedge clk);
    x = 8'sd99; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_ov", out_valid, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    sample(33, 0, 0, 0);
    chk("post_rst_pass", y, 33);
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int a = 0; a < 5; a++) wr(a, int'($urandom_range(255)) - 128);
      for (int k = 0; k < 12; k++) sample(int'($urandom_range(255)) - 128, int'($urandom_range(2)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
